rv32_bht_predictor: RTL and testbench
=====================================

Name: rv32_bht_predictor

Overview:
- Parametrised dynamic branch predictor for the priRV32 fetch stage: table of ENTRIES saturating counters with optional global-history (gshare) indexing.
- Fetch presents PC, decoded immediate and branch/JAL flags. The block returns a registered taken/target prediction plus an index and history snapshot that travel down the pipe.
- The execute stage returns the resolved outcome through the update port, which trains the counters and repairs the global history on mispredict.

Parameters:
- ENTRIES, 64, number of counters; power of 2, ≥4; IDX_W = log2(ENTRIES).
- CTR_W, 2, counter width in bits; ≥1.
- GHR_W, 0, global history length; 0 = pure bimodal; GHR_W ≤ IDX_W. Port width GW = max(GHR_W,1).

Ports:
- clk_i  in  1  clock, posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- pred_valid_i  in  1  lookup request this cycle.
- pred_pc_i  in  32  PC of fetched instruction.
- pred_imm_i  in  32  sign-extended B/J immediate.
- pred_is_branch_i  in  1  instruction is Bxx.
- pred_is_jal_i  in  1  instruction is JAL.
- pred_valid_o  out  1  prediction valid (1-cycle latency).
- pred_taken_o  out  1  predicted taken.
- pred_target_o  out  32  predicted next PC.
- pred_index_o  out  IDX_W  table index used (for update).
- pred_ghr_o  out  GW  GHR value before this lookup's shift.
- upd_valid_i  in  1  resolved branch update.
- upd_index_i  in  IDX_W  index returned from pred_index_o.
- upd_taken_i  in  1  actual outcome.
- upd_mispredict_i  in  1  predicted direction was wrong.
- upd_ghr_i  in  GW  pred_ghr_o snapshot of the resolved branch.
- mispred_cnt_o  out  32  saturating mispredict counter.

Behaviour:
- Reset (async, rst_n=0):
  - All counters = 2^(CTR_W-1)-1 (weakly not-taken; 01 for CTR_W=2).
  - GHR=0; mispred_cnt_o=0.
  - pred_valid_o, pred_taken_o, pred_target_o, pred_index_o, pred_ghr_o all 0.
  - An in-flight update is dropped.
- Index: idx = pred_pc_i[IDX_W+1:2] XOR zero-extended GHR. GHR_W=0 → no XOR.
- Direction: taken = counter MSB. JAL is always taken and does not read the table. Non-branch/non-JAL is not-taken.
- Target: taken → pred_pc_i + pred_imm_i, else pred_pc_i + 4. Mod 2^32, wrap-around allowed.
- Output timing:
  - Outputs are registered: the posedge after pred_valid_i=1 loads all pred_* outputs and sets pred_valid_o=1 for exactly one cycle per request.
  - pred_valid_i=0 → pred_valid_o=0; other outputs hold their previous values.
- Counter update, at posedge with upd_valid_i=1:
  - table[upd_index_i] increments if upd_taken_i, decrements otherwise.
  - Saturates at 0 and at 2^CTR_W-1.
  - upd_mispredict_i does not alter counter arithmetic.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update value (no bypass).
- GHR (GHR_W>0 only):
  - Speculative: pred_valid_i && pred_is_branch_i → GHR <= {GHR[GHR_W-2:0], predicted taken}.
  - Repair: upd_valid_i && upd_mispredict_i → GHR <= {upd_ghr_i[GHR_W-2:0], upd_taken_i}.
  - Repair has priority over a speculative shift in the same cycle; the concurrent lookup still indexes with the old GHR.
  - For GHR_W=1, the shifted-in bit alone is the new GHR.
  - JAL never shifts the GHR.
- GHR_W=0: pred_ghr_o=0 and upd_ghr_i is ignored.
- mispred_cnt_o increments on each upd_valid_i && upd_mispredict_i and holds at 32'hFFFFFFFF.
- X-free: all outputs are defined after reset regardless of input X on unused fields.

Test Plan:
1. Reset with ENTRIES=64, GHR_W=0; lookup branch pc=0x100, imm=0x20 → next cycle: valid=1, taken=0, target=0x104, index=0.
2. Three updates (index 0, taken=1); then lookup pc=0x100 → taken=1, target=0x120. Further taken updates keep the counter at 3. Four not-taken updates → counter 0, predicts not-taken.
3. JAL pc=0xFFFFFFF0, imm=0x20 → taken=1, target=0x00000010 (wrap); GHR unchanged; table untouched.
4. GHR_W=4: three branches predicted taken → GHR=0111. Mispredict update with upd_ghr_i=0011, taken=0, plus same-cycle branch lookup → GHR=0110, lookup's pred_ghr_o=0111, mispred_cnt_o=1.
5. Same-cycle lookup and taken update on index 5 (counter 01) → prediction not-taken; the following lookup predicts taken.
6. Assert rst_n low mid-stream with pending upd_valid_i → counters 01, GHR=0, pred_valid_o=0, mispred_cnt_o=0 immediately, without a clock edge.

Source files
------------

// File: rtl/rv32_bht_predictor.sv
// Dynamic branch predictor: saturating-counter table, optional gshare indexing.
// Latency: one cycle from pred_valid_i to the registered pred_* outputs.
// Backpressure: none. A lookup and an update are accepted on every cycle.
//
// Ports:
//   clk_i, rst_n            clock (posedge) and asynchronous active-low reset
//   pred_valid_i            lookup request: pred_pc_i, pred_imm_i and the
//                           pred_is_branch_i / pred_is_jal_i flags
//   pred_valid_o            registered response, valid for one cycle per request:
//                           pred_taken_o, pred_target_o, pred_index_o, pred_ghr_o
//   upd_valid_i             resolved branch: upd_index_i, upd_taken_i,
//                           upd_mispredict_i, upd_ghr_i
//   mispred_cnt_o           saturating count of mispredicted updates
module rv32_bht_predictor #(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int GHR_W   = 0,
    localparam int IDX_W  = $clog2(ENTRIES),
    localparam int GW     = (GHR_W > 0) ? GHR_W : 1
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             pred_valid_i,
    input  logic [31:0]      pred_pc_i,
    input  logic [31:0]      pred_imm_i,
    input  logic             pred_is_branch_i,
    input  logic             pred_is_jal_i,
    output logic             pred_valid_o,
    output logic             pred_taken_o,
    output logic [31:0]      pred_target_o,
    output logic [IDX_W-1:0] pred_index_o,
    output logic [GW-1:0]    pred_ghr_o,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_index_i,
    input  logic             upd_taken_i,
    input  logic             upd_mispredict_i,
    input  logic [GW-1:0]    upd_ghr_i,
    output logic [31:0]      mispred_cnt_o
);

    // Counters start weakly not-taken.
    localparam logic [CTR_W-1:0] CTR_RST = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    logic [CTR_W-1:0] ctr_q [ENTRIES];
    logic [GW-1:0]    ghr_q;
    logic [IDX_W-1:0] ghr_ext;
    logic [IDX_W-1:0] lk_idx;
    logic [CTR_W-1:0] lk_ctr;
    logic             lk_taken;
    logic [31:0]      lk_target;

    // Lookup path. The table is read before this cycle's update lands, so a
    // same-cycle lookup of the index being trained sees the old counter.
    assign lk_idx    = pred_pc_i[IDX_W+1:2] ^ ghr_ext;
    assign lk_ctr    = ctr_q[lk_idx];
    assign lk_taken  = pred_is_jal_i | (pred_is_branch_i & lk_ctr[CTR_W-1]);
    assign lk_target = lk_taken ? (pred_pc_i + pred_imm_i) : (pred_pc_i + 32'd4);

    // Global history. Absent in bimodal mode: it reads as zero and leaves the
    // index untouched.
    generate
        if (GHR_W == 0) begin : g_bimodal
            assign ghr_q   = '0;
            assign ghr_ext = '0;
        end else begin : g_gshare
            logic [GHR_W-1:0] spec_nxt;
            logic [GHR_W-1:0] fix_nxt;

            if (GHR_W == 1) begin : g_w1
                assign spec_nxt = lk_taken;
                assign fix_nxt  = upd_taken_i;
            end else begin : g_wn
                assign spec_nxt = {ghr_q[GHR_W-2:0], lk_taken};
                assign fix_nxt  = {upd_ghr_i[GHR_W-2:0], upd_taken_i};
            end

            // The repair rebuilds history from the resolved branch's snapshot.
            // It therefore wins over any younger speculative shift in the same
            // cycle.
            always_ff @(posedge clk_i or negedge rst_n) begin
                if (!rst_n) begin
                    ghr_q <= '0;
                end else if (upd_valid_i && upd_mispredict_i) begin
                    ghr_q <= fix_nxt;
                end else if (pred_valid_i && pred_is_branch_i) begin
                    ghr_q <= spec_nxt;
                end
            end

            assign ghr_ext = IDX_W'(ghr_q);
        end
    endgenerate

    // Counter training. The mispredict flag plays no part in the arithmetic.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RST;
            end
        end else if (upd_valid_i) begin
            if (upd_taken_i) begin
                if (ctr_q[upd_index_i] != CTR_MAX) begin
                    ctr_q[upd_index_i] <= ctr_q[upd_index_i] + CTR_W'(1);
                end
            end else if (ctr_q[upd_index_i] != '0) begin
                ctr_q[upd_index_i] <= ctr_q[upd_index_i] - CTR_W'(1);
            end
        end
    end

    // Registered prediction. The payload holds between requests.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_o  <= 1'b0;
            pred_taken_o  <= 1'b0;
            pred_target_o <= '0;
            pred_index_o  <= '0;
            pred_ghr_o    <= '0;
        end else begin
            pred_valid_o <= pred_valid_i;
            if (pred_valid_i) begin
                pred_taken_o  <= lk_taken;
                pred_target_o <= lk_target;
                pred_index_o  <= lk_idx;
                pred_ghr_o    <= ghr_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            mispred_cnt_o <= '0;
        end else if (upd_valid_i && upd_mispredict_i && (mispred_cnt_o != 32'hFFFF_FFFF)) begin
            mispred_cnt_o <= mispred_cnt_o + 32'd1;
        end
    end

    // Only the counter MSB steers direction. The snapshot MSB is shifted out
    // on repair, and the snapshot is unused entirely in bimodal mode.
    logic unused_bits;
    assign unused_bits = ^{upd_ghr_i, lk_ctr};

endmodule

// File: tb/tb_rv32_bht_predictor.sv
module tb_rv32_bht_predictor;

    logic        clk_i;
    logic        rst_n;
    logic        pred_valid_i;
    logic [31:0] pred_pc_i;
    logic [31:0] pred_imm_i;
    logic        pred_is_branch_i;
    logic        pred_is_jal_i;
    logic        upd_valid_i;
    logic [5:0]  upd_index_i;
    logic        upd_taken_i;
    logic        upd_mispredict_i;
    logic [0:0]  upd_ghr0;
    logic [3:0]  upd_ghr4;

    // bimodal instance
    logic        pv0, pt0;
    logic [31:0] ptg0, mc0;
    logic [5:0]  pi0;
    logic [0:0]  pg0;
    // gshare instance, 4-bit history
    logic        pv4, pt4;
    logic [31:0] ptg4, mc4;
    logic [5:0]  pi4;
    logic [3:0]  pg4;

    int nchk = 0;
    int nbad = 0;

    rv32_bht_predictor #(.ENTRIES(64), .CTR_W(2), .GHR_W(0)) dut0 (
        .clk_i(clk_i), .rst_n(rst_n),
        .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i), .pred_imm_i(pred_imm_i),
        .pred_is_branch_i(pred_is_branch_i), .pred_is_jal_i(pred_is_jal_i),
        .pred_valid_o(pv0), .pred_taken_o(pt0), .pred_target_o(ptg0),
        .pred_index_o(pi0), .pred_ghr_o(pg0),
        .upd_valid_i(upd_valid_i), .upd_index_i(upd_index_i), .upd_taken_i(upd_taken_i),
        .upd_mispredict_i(upd_mispredict_i), .upd_ghr_i(upd_ghr0),
        .mispred_cnt_o(mc0)
    );

    rv32_bht_predictor #(.ENTRIES(64), .CTR_W(2), .GHR_W(4)) dut4 (
        .clk_i(clk_i), .rst_n(rst_n),
        .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i), .pred_imm_i(pred_imm_i),
        .pred_is_branch_i(pred_is_branch_i), .pred_is_jal_i(pred_is_jal_i),
        .pred_valid_o(pv4), .pred_taken_o(pt4), .pred_target_o(ptg4),
        .pred_index_o(pi4), .pred_ghr_o(pg4),
        .upd_valid_i(upd_valid_i), .upd_index_i(upd_index_i), .upd_taken_i(upd_taken_i),
        .upd_mispredict_i(upd_mispredict_i), .upd_ghr_i(upd_ghr4),
        .mispred_cnt_o(mc4)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs;
        pred_valid_i     = 1'b0;
        pred_is_branch_i = 1'b0;
        pred_is_jal_i    = 1'b0;
        upd_valid_i      = 1'b0;
        upd_taken_i      = 1'b0;
        upd_mispredict_i = 1'b0;
    endtask

    task automatic set_lookup(input logic [31:0] pc, input logic [31:0] imm,
                              input logic br, input logic jal);
        pred_valid_i     = 1'b1;
        pred_pc_i        = pc;
        pred_imm_i       = imm;
        pred_is_branch_i = br;
        pred_is_jal_i    = jal;
    endtask

    task automatic set_upd(input logic [5:0] idx, input logic tk, input logic mp,
                           input logic [3:0] g);
        upd_valid_i      = 1'b1;
        upd_index_i      = idx;
        upd_taken_i      = tk;
        upd_mispredict_i = mp;
        upd_ghr4         = g;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [31:0] imm,
                          input logic br, input logic jal);
        set_lookup(pc, imm, br, jal);
        tick;
        clear_inputs;
    endtask

    task automatic upd(input logic [5:0] idx, input logic tk, input logic mp,
                       input logic [3:0] g);
        set_upd(idx, tk, mp, g);
        tick;
        clear_inputs;
    endtask

    task automatic do_reset;
        clear_inputs;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        nchk++; if (pv0 !== 1'b0) begin nbad++; $display("FAIL rst_valid got=%0h exp=0", pv0); end
        nchk++; if (pt0 !== 1'b0) begin nbad++; $display("FAIL rst_taken got=%0h exp=0", pt0); end
        nchk++; if (ptg0 !== 32'h0) begin nbad++; $display("FAIL rst_target got=%h exp=0", ptg0); end
        nchk++; if (pi0 !== 6'd0) begin nbad++; $display("FAIL rst_index got=%0d exp=0", pi0); end
        nchk++; if (mc0 !== 32'h0) begin nbad++; $display("FAIL rst_mcnt got=%0d exp=0", mc0); end
        nchk++; if (pg4 !== 4'h0) begin nbad++; $display("FAIL rst_ghr4 got=%h exp=0", pg4); end
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_lookup;
        lookup(32'h100, 32'h20, 1'b1, 1'b0);
        nchk++; if (pv0 !== 1'b1) begin nbad++; $display("FAIL lk_valid got=%0h exp=1", pv0); end
        nchk++; if (pt0 !== 1'b0) begin nbad++; $display("FAIL lk_taken got=%0h exp=0", pt0); end
        nchk++; if (ptg0 !== 32'h104) begin nbad++; $display("FAIL lk_target got=%h exp=104", ptg0); end
        nchk++; if (pi0 !== 6'd0) begin nbad++; $display("FAIL lk_index got=%0d exp=0", pi0); end
        nchk++; if (pg0 !== 1'b0) begin nbad++; $display("FAIL lk_ghr0 got=%0h exp=0", pg0); end
        tick;
        nchk++; if (pv0 !== 1'b0) begin nbad++; $display("FAIL lk_valid_drop got=%0h exp=0", pv0); end
        nchk++; if (ptg0 !== 32'h104) begin nbad++; $display("FAIL lk_target_hold got=%h exp=104", ptg0); end
    endtask

    task automatic test_train;
        for (int i = 0; i < 3; i++) upd(6'd0, 1'b1, 1'b0, 4'd0);
        lookup(32'h100, 32'h20, 1'b1, 1'b0);
        nchk++; if (pt0 !== 1'b1) begin nbad++; $display("FAIL tr_taken3 got=%0h exp=1", pt0); end
        nchk++; if (ptg0 !== 32'h120) begin nbad++; $display("FAIL tr_target3 got=%h exp=120", ptg0); end
        // top saturation: 3 stays 3, one decrement leaves it taken
        for (int i = 0; i < 2; i++) upd(6'd0, 1'b1, 1'b0, 4'd0);
        upd(6'd0, 1'b0, 1'b0, 4'd0);
        lookup(32'h100, 32'h20, 1'b1, 1'b0);
        nchk++; if (pt0 !== 1'b1) begin nbad++; $display("FAIL tr_sat_hi got=%0h exp=1", pt0); end
        // bottom saturation: 2 -> 0 and stays 0
        for (int i = 0; i < 4; i++) upd(6'd0, 1'b0, 1'b0, 4'd0);
        lookup(32'h100, 32'h20, 1'b1, 1'b0);
        nchk++; if (pt0 !== 1'b0) begin nbad++; $display("FAIL tr_zero got=%0h exp=0", pt0); end
        nchk++; if (ptg0 !== 32'h104) begin nbad++; $display("FAIL tr_zero_tgt got=%h exp=104", ptg0); end
        for (int i = 0; i < 2; i++) upd(6'd0, 1'b1, 1'b0, 4'd0);
        lookup(32'h100, 32'h20, 1'b1, 1'b0);
        nchk++; if (pt0 !== 1'b1) begin nbad++; $display("FAIL tr_sat_lo got=%0h exp=1", pt0); end
        // a plain instruction is never predicted taken
        lookup(32'h100, 32'h20, 1'b0, 1'b0);
        nchk++; if (pt0 !== 1'b0) begin nbad++; $display("FAIL tr_plain got=%0h exp=0", pt0); end
        nchk++; if (ptg0 !== 32'h104) begin nbad++; $display("FAIL tr_plain_tgt got=%h exp=104", ptg0); end
    endtask

    task automatic test_jal;
        lookup(32'hFFFF_FFF0, 32'h20, 1'b0, 1'b1);
        nchk++; if (pt0 !== 1'b1) begin nbad++; $display("FAIL jal_taken got=%0h exp=1", pt0); end
        nchk++; if (ptg0 !== 32'h10) begin nbad++; $display("FAIL jal_wrap got=%h exp=00000010", ptg0); end
        lookup(32'hFFFF_FFF0, 32'h20, 1'b1, 1'b0);
        nchk++; if (pt0 !== 1'b0) begin nbad++; $display("FAIL jal_table got=%0h exp=0", pt0); end
        nchk++; if (ptg0 !== 32'hFFFF_FFF4) begin nbad++; $display("FAIL jal_br_tgt got=%h exp=fffffff4", ptg0); end
        nchk++; if (pi0 !== 6'd60) begin nbad++; $display("FAIL jal_br_idx got=%0d exp=60", pi0); end
    endtask

    task automatic test_ghr;
        do_reset;
        upd(6'd0, 1'b1, 1'b0, 4'd0);
        upd(6'd1, 1'b1, 1'b0, 4'd0);
        upd(6'd3, 1'b1, 1'b0, 4'd0);
        lookup(32'h100, 32'h20, 1'b1, 1'b0);
        nchk++; if (pt4 !== 1'b1) begin nbad++; $display("FAIL gh_taken1 got=%0h exp=1", pt4); end
        nchk++; if (pg4 !== 4'b0000) begin nbad++; $display("FAIL gh_ghr1 got=%b exp=0000", pg4); end
        lookup(32'h100, 32'h20, 1'b1, 1'b0);
        nchk++; if (pi4 !== 6'd1) begin nbad++; $display("FAIL gh_idx2 got=%0d exp=1", pi4); end
        nchk++; if (pg4 !== 4'b0001) begin nbad++; $display("FAIL gh_ghr2 got=%b exp=0001", pg4); end
        lookup(32'h100, 32'h20, 1'b1, 1'b0);
        nchk++; if (pi4 !== 6'd3) begin nbad++; $display("FAIL gh_idx3 got=%0d exp=3", pi4); end
        nchk++; if (pg4 !== 4'b0011) begin nbad++; $display("FAIL gh_ghr3 got=%b exp=0011", pg4); end
        nchk++; if (pt4 !== 1'b1) begin nbad++; $display("FAIL gh_taken3 got=%0h exp=1", pt4); end
        // repair plus concurrent branch lookup
        set_lookup(32'h100, 32'h20, 1'b1, 1'b0);
        set_upd(6'd7, 1'b0, 1'b1, 4'b0011);
        tick;
        clear_inputs;
        nchk++; if (pi4 !== 6'd7) begin nbad++; $display("FAIL gh_rep_idx got=%0d exp=7", pi4); end
        nchk++; if (pg4 !== 4'b0111) begin nbad++; $display("FAIL gh_rep_snap got=%b exp=0111", pg4); end
        nchk++; if (pt4 !== 1'b0) begin nbad++; $display("FAIL gh_rep_taken got=%0h exp=0", pt4); end
        nchk++; if (mc4 !== 32'd1) begin nbad++; $display("FAIL gh_mcnt got=%0d exp=1", mc4); end
        lookup(32'h100, 32'h20, 1'b0, 1'b1);
        nchk++; if (pg4 !== 4'b0110) begin nbad++; $display("FAIL gh_repaired got=%b exp=0110", pg4); end
        nchk++; if (ptg4 !== 32'h120) begin nbad++; $display("FAIL gh_jal_tgt got=%h exp=120", ptg4); end
        lookup(32'h100, 32'h20, 1'b1, 1'b0);
        nchk++; if (pg4 !== 4'b0110) begin nbad++; $display("FAIL gh_jal_noshift got=%b exp=0110", pg4); end
        nchk++; if (pi4 !== 6'd6) begin nbad++; $display("FAIL gh_idx6 got=%0d exp=6", pi4); end
    endtask

    task automatic test_same_cycle;
        set_lookup(32'h114, 32'h40, 1'b1, 1'b0);
        set_upd(6'd5, 1'b1, 1'b0, 4'd0);
        tick;
        clear_inputs;
        nchk++; if (pi0 !== 6'd5) begin nbad++; $display("FAIL sc_index got=%0d exp=5", pi0); end
        nchk++; if (pt0 !== 1'b0) begin nbad++; $display("FAIL sc_nobypass got=%0h exp=0", pt0); end
        nchk++; if (ptg0 !== 32'h118) begin nbad++; $display("FAIL sc_target got=%h exp=118", ptg0); end
        lookup(32'h114, 32'h40, 1'b1, 1'b0);
        nchk++; if (pt0 !== 1'b1) begin nbad++; $display("FAIL sc_after got=%0h exp=1", pt0); end
        nchk++; if (ptg0 !== 32'h154) begin nbad++; $display("FAIL sc_after_tgt got=%h exp=154", ptg0); end
    endtask

    task automatic test_async_reset;
        upd(6'd1, 1'b1, 1'b0, 4'd0);
        set_lookup(32'h104, 32'h20, 1'b1, 1'b0);
        set_upd(6'd1, 1'b0, 1'b1, 4'd0);
        tick;
        nchk++; if (pt0 !== 1'b1) begin nbad++; $display("FAIL ar_pre_taken got=%0h exp=1", pt0); end
        nchk++; if (ptg0 !== 32'h124) begin nbad++; $display("FAIL ar_pre_tgt got=%h exp=124", ptg0); end
        nchk++; if (mc0 !== 32'd2) begin nbad++; $display("FAIL ar_pre_mcnt got=%0d exp=2", mc0); end
        // reset asserted between edges with requests still pending
        @(negedge clk_i);
        #1;
        rst_n = 1'b0;
        #1;
        nchk++; if (pv0 !== 1'b0) begin nbad++; $display("FAIL ar_valid got=%0h exp=0", pv0); end
        nchk++; if (pt0 !== 1'b0) begin nbad++; $display("FAIL ar_taken got=%0h exp=0", pt0); end
        nchk++; if (ptg0 !== 32'h0) begin nbad++; $display("FAIL ar_target got=%h exp=0", ptg0); end
        nchk++; if (pi0 !== 6'd0) begin nbad++; $display("FAIL ar_index got=%0d exp=0", pi0); end
        nchk++; if (mc0 !== 32'd0) begin nbad++; $display("FAIL ar_mcnt got=%0d exp=0", mc0); end
        tick;
        clear_inputs;
        rst_n = 1'b1;
        lookup(32'h104, 32'h20, 1'b1, 1'b0);
        nchk++; if (pt0 !== 1'b0) begin nbad++; $display("FAIL ar_ctr_nt got=%0h exp=0", pt0); end
        nchk++; if (pg4 !== 4'b0000) begin nbad++; $display("FAIL ar_ghr got=%b exp=0000", pg4); end
        nchk++; if (mc0 !== 32'd0) begin nbad++; $display("FAIL ar_mcnt_hold got=%0d exp=0", mc0); end
        upd(6'd1, 1'b1, 1'b0, 4'd0);
        lookup(32'h104, 32'h20, 1'b1, 1'b0);
        nchk++; if (pt0 !== 1'b1) begin nbad++; $display("FAIL ar_ctr_01 got=%0h exp=1", pt0); end
    endtask

    initial begin
        rst_n       = 1'b1;
        pred_pc_i   = '0;
        pred_imm_i  = '0;
        upd_index_i = '0;
        upd_ghr0    = '0;
        upd_ghr4    = '0;
        clear_inputs;
        #1;
        rst_n = 1'b0;
        #2;
        test_reset;
        test_lookup;
        test_train;
        test_jal;
        test_ghr;
        test_same_cycle;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end

endmodule
